// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 access encodings,
// write-back select values, ctrl_wb bit positions and the MEM FSM states.
// No logic; constants and types only.
package riscv_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // Write-back select values held in ctrl[2:1]
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Register-write enable bit within ctrl_mem / ctrl_wb
  localparam int CTRL_REG_WE = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Purpose: store strobe/lane generation, load byte/half extraction and extension,
//          misaligned/illegal access detection for one RV32I memory access.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: funct3/addr_lo/is_store describe the access; store_data/rdata are the
//        raw words; wstrb/wdata/load_val/fault are the aligned results.
module mem_stage_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        fault
);

  logic        illegal;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    if (is_store)
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else
      illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                  funct3 == F3_BU || funct3 == F3_HU);
  end

  // funct3[1:0] gives the size for both signed and unsigned variants
  assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  assign fault = illegal | misaligned;

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      F3_W: wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'd0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'd0, half_sel};
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Purpose: RV32I MEM stage - data-memory handshake, load/store alignment, MEM/WB register.
// Latency: 1 cycle from completion (non-access, or dmem_ready) to the WB outputs.
// Backpressure: stall_mem = dmem_req & ~dmem_ready holds upstream; WB gets bubbles meanwhile.
// Ports: clk/rst; MEM-side instruction fields (valid_mem, ctrl_mem, mem_rd, mem_wr,
//        funct3, alu_result, store_data, pc4_mem, rd_mem); dmem_* request/response;
//        stall_mem, access_err; registered WB outputs ctrl_wb, pc4_wb, mem_data, alu_data, rd_wb.
module mem_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_mem,
  input  logic [2:0]  ctrl_mem,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] pc4_mem,
  input  logic [4:0]  rd_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        access_err,
  output logic [2:0]  ctrl_wb,
  output logic [31:0] pc4_wb,
  output logic [31:0] mem_data,
  output logic [31:0] alu_data,
  output logic [4:0]  rd_wb
);

  mem_state_t  state;
  logic        is_load;
  logic        is_store;
  logic        access;
  logic        fault;
  logic        legal_access;
  logic [3:0]  strb;
  logic [31:0] load_val;

  mem_stage_lsu_align u_align (
    .funct3     (funct3),
    .addr_lo    (alu_result[1:0]),
    .is_store   (mem_wr),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .wstrb      (strb),
    .wdata      (dmem_wdata),
    .load_val   (load_val),
    .fault      (fault)
  );

  assign is_load      = valid_mem & mem_rd;
  assign is_store     = valid_mem & mem_wr;
  assign access       = is_load | is_store;
  assign legal_access = access & ~fault;

  // Gated by rst so a reset during WAIT withdraws the request immediately.
  assign dmem_req   = ~rst & ((state == S_WAIT) | legal_access);
  assign dmem_we    = dmem_req & mem_wr;
  assign dmem_wstrb = dmem_we ? strb : 4'b0000;
  assign dmem_addr  = {alu_result[31:2], 2'b00};
  assign stall_mem  = dmem_req & ~dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      access_err <= 1'b0;
      ctrl_wb    <= 3'b000;
      pc4_wb     <= 32'd0;
      mem_data   <= 32'd0;
      alu_data   <= 32'd0;
      rd_wb      <= 5'd0;
    end else begin
      access_err <= access & fault;

      case (state)
        S_IDLE:  if (dmem_req && !dmem_ready) state <= S_WAIT;
        S_WAIT:  if (dmem_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (stall_mem || !valid_mem) begin
        // Bubble: kill write-back, leave operand fields as they were
        ctrl_wb <= 3'b000;
      end else begin
        ctrl_wb              <= ctrl_mem;
        ctrl_wb[CTRL_REG_WE] <= ctrl_mem[CTRL_REG_WE] & ~(access & fault);
        pc4_wb               <= pc4_mem;
        alu_data             <= alu_result;
        rd_wb                <= rd_mem;
        mem_data             <= (is_load & ~fault) ? load_val : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Inputs are driven at the falling edge; outputs are sampled away from the rising edge.
// Each scenario task carries its own expected values.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem;
  logic [2:0]  ctrl_mem;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] pc4_mem;
  logic [4:0]  rd_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic        access_err;
  logic [2:0]  ctrl_wb;
  logic [31:0] pc4_wb;
  logic [31:0] mem_data;
  logic [31:0] alu_data;
  logic [4:0]  rd_wb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .valid_mem  (valid_mem),
    .ctrl_mem   (ctrl_mem),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .funct3     (funct3),
    .alu_result (alu_result),
    .store_data (store_data),
    .pc4_mem    (pc4_mem),
    .rd_mem     (rd_mem),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .stall_mem  (stall_mem),
    .access_err (access_err),
    .ctrl_wb    (ctrl_wb),
    .pc4_wb     (pc4_wb),
    .mem_data   (mem_data),
    .alu_data   (alu_data),
    .rd_wb      (rd_wb)
  );

  task automatic idle_inputs();
    valid_mem  = 1'b0;
    ctrl_mem   = 3'b000;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    funct3     = 3'b000;
    alu_result = 32'd0;
    store_data = 32'd0;
    pc4_mem    = 32'd0;
    rd_mem     = 5'd0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
  endtask

  task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [2:0] ctrl,
                          input logic [31:0] pc4, input logic [4:0] rd);
    valid_mem  = 1'b1;
    mem_rd     = 1'b1;
    mem_wr     = 1'b0;
    funct3     = f3;
    alu_result = addr;
    ctrl_mem   = ctrl;
    pc4_mem    = pc4;
    rd_mem     = rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    // A legal load presented during reset must not raise a request
    set_load(3'b010, 32'h100, 3'b011, 32'h4, 5'd1);
    dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    tests++; if (stall_mem !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_mem); end
    tests++; if (dmem_wstrb !== 4'b0000) begin fails++; $display("FAIL reset_wstrb got=%b exp=0000", dmem_wstrb); end
    tests++; if (ctrl_wb !== 3'b000) begin fails++; $display("FAIL reset_ctrl_wb got=%b exp=000", ctrl_wb); end
    tests++; if ({pc4_wb, mem_data, alu_data} !== 96'd0) begin fails++; $display("FAIL reset_wb_data got=%h/%h/%h exp=0", pc4_wb, mem_data, alu_data); end
    tests++; if (rd_wb !== 5'd0 || access_err !== 1'b0) begin fails++; $display("FAIL reset_rd_err got=%0d/%b exp=0/0", rd_wb, access_err); end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw_zero_wait();
    set_load(3'b010, 32'h100, 3'b011, 32'h1004, 5'd5);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    tests++; if (dmem_req !== 1'b1 || stall_mem !== 1'b0) begin fails++; $display("FAIL lw_req_stall got=%b/%b exp=1/0", dmem_req, stall_mem); end
    tests++; if (dmem_addr !== 32'h100 || dmem_we !== 1'b0 || dmem_wstrb !== 4'b0000) begin fails++; $display("FAIL lw_fields got=%h/%b/%b exp=100/0/0000", dmem_addr, dmem_we, dmem_wstrb); end
    @(negedge clk);
    idle_inputs();
    tests++; if (mem_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_mem_data got=%h exp=deadbeef", mem_data); end
    tests++; if (ctrl_wb !== 3'b011 || rd_wb !== 5'd5 || pc4_wb !== 32'h1004 || alu_data !== 32'h100) begin fails++; $display("FAIL lw_wb got=%b/%0d/%h/%h exp=011/5/1004/100", ctrl_wb, rd_wb, pc4_wb, alu_data); end
  endtask

  task automatic test_lb_wait(input logic [2:0] f3, input logic [31:0] exp_data);
    set_load(f3, 32'h103, 3'b011, 32'h2008, 5'd7);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h80FF_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (stall_mem !== 1'b1 || dmem_req !== 1'b1) begin fails++; $display("FAIL lb_stall[%0d] f3=%b got=%b/%b exp=1/1", i, f3, stall_mem, dmem_req); end
      @(negedge clk);
      tests++; if (ctrl_wb !== 3'b000) begin fails++; $display("FAIL lb_bubble[%0d] f3=%b got=%b exp=000", i, f3, ctrl_wb); end
    end
    dmem_ready = 1'b1;
    #1;
    tests++; if (stall_mem !== 1'b0 || dmem_addr !== 32'h100) begin fails++; $display("FAIL lb_release f3=%b got=%b/%h exp=0/100", f3, stall_mem, dmem_addr); end
    @(negedge clk);
    idle_inputs();
    tests++; if (mem_data !== exp_data || ctrl_wb !== 3'b011 || rd_wb !== 5'd7) begin fails++; $display("FAIL lb_result f3=%b got=%h/%b/%0d exp=%h/011/7", f3, mem_data, ctrl_wb, rd_wb, exp_data); end
    #1;
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL lb_idle_req got=%b exp=0", dmem_req); end
  endtask

  task automatic test_store();
    valid_mem  = 1'b1;
    mem_wr     = 1'b1;
    mem_rd     = 1'b0;
    funct3     = 3'b001;
    alu_result = 32'h202;
    store_data = 32'h1234ABCD;
    ctrl_mem   = 3'b000;
    dmem_ready = 1'b1;
    #1;
    tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200) begin fails++; $display("FAIL sh_req got=%b/%b/%h exp=1/1/200", dmem_req, dmem_we, dmem_addr); end
    tests++; if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hABCDABCD) begin fails++; $display("FAIL sh_lanes got=%b/%h exp=1100/abcdabcd", dmem_wstrb, dmem_wdata); end
    @(negedge clk);
    // SB on byte lane 1 directly behind the SH
    funct3     = 3'b000;
    alu_result = 32'h201;
    store_data = 32'h000000CD;
    #1;
    tests++; if (dmem_wstrb !== 4'b0010 || dmem_wdata !== 32'hCDCDCDCD || dmem_addr !== 32'h200) begin fails++; $display("FAIL sb_lanes got=%b/%h/%h exp=0010/cdcdcdcd/200", dmem_wstrb, dmem_wdata, dmem_addr); end
    @(negedge clk);
    idle_inputs();
    tests++; if (ctrl_wb !== 3'b000 || mem_data !== 32'd0) begin fails++; $display("FAIL store_wb got=%b/%h exp=000/0", ctrl_wb, mem_data); end
  endtask

  task automatic test_misaligned();
    set_load(3'b010, 32'h101, 3'b011, 32'h3000, 5'd9);
    dmem_ready = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || access_err !== 1'b0) begin fails++; $display("FAIL mis_req got=%b/%b/%b exp=0/0/0", dmem_req, stall_mem, access_err); end
    @(negedge clk);
    idle_inputs();
    tests++; if (access_err !== 1'b1 || ctrl_wb !== 3'b010 || rd_wb !== 5'd9) begin fails++; $display("FAIL mis_err got=%b/%b/%0d exp=1/010/9", access_err, ctrl_wb, rd_wb); end
    @(negedge clk);
    tests++; if (access_err !== 1'b0) begin fails++; $display("FAIL mis_pulse got=%b exp=0", access_err); end
    // Illegal load funct3 011
    set_load(3'b011, 32'h100, 3'b011, 32'h3004, 5'd9);
    #1;
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL illegal_req got=%b exp=0", dmem_req); end
    @(negedge clk);
    idle_inputs();
    tests++; if (access_err !== 1'b1 || ctrl_wb[0] !== 1'b0) begin fails++; $display("FAIL illegal_err got=%b/%b exp=1/0", access_err, ctrl_wb[0]); end
    @(negedge clk);
  endtask

  task automatic test_alu_pass();
    valid_mem  = 1'b1;
    ctrl_mem   = 3'b001;
    alu_result = 32'h55;
    pc4_mem    = 32'h4008;
    rd_mem     = 5'd3;
    dmem_ready = 1'b1;   // stray ready with no request must be ignored
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    tests++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL alu_req got=%b/%b exp=0/0", dmem_req, stall_mem); end
    @(negedge clk);
    idle_inputs();
    tests++; if (alu_data !== 32'h55 || ctrl_wb !== 3'b001 || mem_data !== 32'd0 || rd_wb !== 5'd3) begin fails++; $display("FAIL alu_wb got=%h/%b/%h/%0d exp=55/001/0/3", alu_data, ctrl_wb, mem_data, rd_wb); end
  endtask

  task automatic test_back_to_back();
    set_load(3'b101, 32'h106, 3'b011, 32'h5000, 5'd10);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hBEEF_0000;
    @(negedge clk);
    tests++; if (mem_data !== 32'h0000BEEF) begin fails++; $display("FAIL b2b_lhu got=%h exp=0000beef", mem_data); end
    set_load(3'b001, 32'h106, 3'b011, 32'h5004, 5'd11);
    dmem_rdata = 32'h8001_0000;
    #1;
    tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL b2b_req got=%b exp=1", dmem_req); end
    @(negedge clk);
    idle_inputs();
    tests++; if (mem_data !== 32'hFFFF8001 || rd_wb !== 5'd11) begin fails++; $display("FAIL b2b_lh got=%h/%0d exp=ffff8001/11", mem_data, rd_wb); end
  endtask

  task automatic test_reset_in_wait();
    set_load(3'b010, 32'h100, 3'b011, 32'h6000, 5'd12);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rw_wait_req got=%b exp=1", dmem_req); end
    rst = 1'b1;
    #1;
    tests++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin fails++; $display("FAIL rw_async_drop got=%b/%b exp=0/0", dmem_req, stall_mem); end
    tests++; if (ctrl_wb !== 3'b000 || pc4_wb !== 32'd0 || alu_data !== 32'd0 || rd_wb !== 5'd0) begin fails++; $display("FAIL rw_wb_clear got=%b/%h/%h/%0d exp=0", ctrl_wb, pc4_wb, alu_data, rd_wb); end
    @(negedge clk);
    dmem_ready = 1'b1;
    @(negedge clk);
    tests++; if (mem_data !== 32'd0 || ctrl_wb !== 3'b000) begin fails++; $display("FAIL rw_late_ready got=%h/%b exp=0/000", mem_data, ctrl_wb); end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    // With no valid instruction, a request would only appear if still in WAIT
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL rw_idle got=%b exp=0", dmem_req); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_lw_zero_wait();
    test_lb_wait(3'b000, 32'hFFFFFF80);
    test_lb_wait(3'b100, 32'h00000080);
    test_store();
    test_misaligned();
    test_alu_pass();
    test_back_to_back();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
